// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes as an enum, funct3 encodings as localparams.
package riscv_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_AUIPC  = 7'b0010111,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP     = 7'b0110011,
    OPCODE_LUI    = 7'b0110111,
    OPCODE_BRANCH = 7'b1100011,
    OPCODE_JALR   = 7'b1100111,
    OPCODE_JAL    = 7'b1101111
  } opcode_e;

  localparam logic [2:0] FUNCT3_ADDI      = 3'b000;
  localparam logic [2:0] FUNCT3_SLLI      = 3'b001;
  localparam logic [2:0] FUNCT3_SLTI      = 3'b010;
  localparam logic [2:0] FUNCT3_SLTIU     = 3'b011;
  localparam logic [2:0] FUNCT3_XORI      = 3'b100;
  localparam logic [2:0] FUNCT3_SRLI_SRAI = 3'b101;
  localparam logic [2:0] FUNCT3_ORI       = 3'b110;
  localparam logic [2:0] FUNCT3_ANDI      = 3'b111;

  localparam logic [2:0] FUNCT3_ADD_SUB   = 3'b000;
  localparam logic [2:0] FUNCT3_SLL       = 3'b001;
  localparam logic [2:0] FUNCT3_SLT       = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU      = 3'b011;
  localparam logic [2:0] FUNCT3_XOR       = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA   = 3'b101;
  localparam logic [2:0] FUNCT3_OR        = 3'b110;
  localparam logic [2:0] FUNCT3_AND       = 3'b111;

  localparam logic [2:0] FUNCT3_BEQ       = 3'b000;
  localparam logic [2:0] FUNCT3_BNE       = 3'b001;
  localparam logic [2:0] FUNCT3_BLT       = 3'b100;
  localparam logic [2:0] FUNCT3_BGE       = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU      = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU      = 3'b111;

endpackage

// File: rtl/alu_imm_gen.sv
// Extracts the sign-extended I, S, B, U and J immediates from an RV32I instruction.
module alu_imm_gen (
  input  logic [31:7] instruction,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU with branch-compare flags.
// Define ALU_OUTPUT_REG_EN to register out and flags (1-cycle latency, sync reset).
module alu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] pc,
  output logic [31:0] out,
  output logic        eq,
  output logic        neq,
  output logic        lt,
  output logic        ltu,
  output logic        ge,
  output logic        geu
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  alu_imm_gen u_imm_gen (
    .instruction (instruction[31:7]),
    .imm_i       (imm_i),
    .imm_s       (imm_s),
    .imm_b       (imm_b),
    .imm_u       (imm_u),
    .imm_j       (imm_j)
  );

  opcode_e     opcode;
  logic [2:0]  funct3;
  logic        is_op;
  logic [31:0] opnd_b;
  logic [4:0]  shamt;
  logic [31:0] arith;
  logic [31:0] result;
  logic        f_eq, f_lt, f_ltu;

  assign opcode = opcode_e'(instruction[6:0]);
  assign funct3 = instruction[14:12];
  assign is_op  = (opcode == OPCODE_OP);
  // OP_IMM shares the OP datapath; I-imm[4:0] is exactly instr[24:20], the shift amount.
  assign opnd_b = is_op ? op_b : imm_i;
  assign shamt  = opnd_b[4:0];

  always_comb begin
    arith = '0;
    case (funct3)
      FUNCT3_ADD_SUB: arith = (is_op && instruction[30]) ? op_a - opnd_b : op_a + opnd_b;
      FUNCT3_SLL:     arith = op_a << shamt;
      FUNCT3_SLT:     arith = {31'b0, $signed(op_a) < $signed(opnd_b)};
      FUNCT3_SLTU:    arith = {31'b0, op_a < opnd_b};
      FUNCT3_XOR:     arith = op_a ^ opnd_b;
      FUNCT3_SRL_SRA: arith = instruction[30] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
      FUNCT3_OR:      arith = op_a | opnd_b;
      FUNCT3_AND:     arith = op_a & opnd_b;
      default:        arith = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (opcode)
      OPCODE_OP_IMM,
      OPCODE_OP:     result = arith;
      OPCODE_BRANCH: result = pc + imm_b;
      OPCODE_LUI:    result = imm_u;
      OPCODE_AUIPC:  result = pc + imm_u;
      OPCODE_JAL:    result = pc + imm_j;
      OPCODE_JALR:   result = (op_a + imm_i) & ~32'd1;
      OPCODE_LOAD:   result = op_a + imm_i;
      OPCODE_STORE:  result = op_a + imm_s;
      default:       result = '0;
    endcase
  end

  assign f_eq  = (op_a == op_b);
  assign f_lt  = ($signed(op_a) < $signed(op_b));
  assign f_ltu = (op_a < op_b);

`ifdef ALU_OUTPUT_REG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      eq  <= 1'b0;
      neq <= 1'b0;
      lt  <= 1'b0;
      ltu <= 1'b0;
      ge  <= 1'b0;
      geu <= 1'b0;
    end else begin
      out <= result;
      eq  <= f_eq;
      neq <= ~f_eq;
      lt  <= f_lt;
      ltu <= f_ltu;
      ge  <= ~f_lt;
      geu <= ~f_ltu;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign out = result;
  assign eq  = f_eq;
  assign neq = ~f_eq;
  assign lt  = f_lt;
  assign ltu = f_ltu;
  assign ge  = ~f_lt;
  assign geu = ~f_ltu;
`endif

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against a behavioural RV32I reference model.
// Works for both the combinational and the ALU_OUTPUT_REG_EN builds.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] pc = '0;
  logic [31:0] out;
  logic        eq, neq, lt, ltu, ge, geu;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .op_a        (op_a),
    .op_b        (op_b),
    .pc          (pc),
    .out         (out),
    .eq          (eq),
    .neq         (neq),
    .lt          (lt),
    .ltu         (ltu),
    .ge          (ge),
    .geu         (geu)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
    return {imm, 5'd1, f3, 5'd2, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd1, f3, 5'd2, 7'b0110011};
  endfunction

  // Reference: immediates via arithmetic sign extension, ops via integer semantics.
  function automatic logic [31:0] model_out(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] p);
    int          si;
    int          sb;
    logic [12:0] braw;
    logic [20:0] jraw;
    logic [31:0] x;
    logic [31:0] imm_s;
    logic [31:0] res;
    si    = $signed(ins) >>> 20;
    imm_s = {32'(si) >> 5, ins[11:7]};
    braw  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jraw  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    sb    = int'($signed(braw));
    res   = '0;
    case (ins[6:0])
      7'b0010011, 7'b0110011: begin
        x = (ins[6:0] == 7'b0110011) ? b : 32'(si);
        case (ins[14:12])
          3'd0: res = (ins[6:0] == 7'b0110011 && ins[30]) ? a - x : a + x;
          3'd1: res = a << x[4:0];
          3'd2: res = (int'(a) < int'(x)) ? 32'd1 : 32'd0;
          3'd3: res = (a < x) ? 32'd1 : 32'd0;
          3'd4: res = a ^ x;
          3'd5: res = ins[30] ? 32'(int'(a) >>> x[4:0]) : a >> x[4:0];
          3'd6: res = a | x;
          default: res = a & x;
        endcase
      end
      7'b1100011: res = p + 32'(sb);
      7'b0110111: res = ins & 32'hFFFF_F000;
      7'b0010111: res = p + (ins & 32'hFFFF_F000);
      7'b1101111: res = p + 32'(int'($signed(jraw)));
      7'b1100111: res = (a + 32'(si)) & 32'hFFFF_FFFE;
      7'b0000011: res = a + 32'(si);
      7'b0100011: res = a + imm_s;
      default:    res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [5:0] model_flags(input logic [31:0] a, input logic [31:0] b);
    return {a == b, a != b, int'(a) < int'(b), a < b, int'(a) >= int'(b), a >= b};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p);
    @(negedge clk);
    instruction = ins;
    op_a = a;
    op_b = b;
    pc   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_model(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] p);
    drive(ins, a, b, p);
    check({tag, "/out"}, out, model_out(ins, a, b, p));
    check({tag, "/flags"}, {26'b0, eq, neq, lt, ltu, ge, geu}, {26'b0, model_flags(a, b)});
  endtask

  task automatic run_exp(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] exp);
    drive(ins, a, b, p);
    check(tag, out, exp);
  endtask

  logic [6:0] opcodes [10] = '{7'b0010011, 7'b0110011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0001111};

  initial begin
    logic [31:0] r, a, b, p;
    logic [6:0]  opc;

    @(posedge clk);
    #1;
`ifdef ALU_OUTPUT_REG_EN
    check("reset/out", out, 32'h0);
    check("reset/flags", {26'b0, eq, neq, lt, ltu, ge, geu}, 32'h0);
`else
    check("reset/out", out, 32'h0);
    check("reset/flags", {26'b0, eq, neq, lt, ltu, ge, geu}, 32'b100011);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_exp("addi_neg2048", enc_i(12'h800, 3'd0, 7'b0010011), 32'h8000_0000, 32'h0, 32'h0, 32'h7FFF_F800);
    run_exp("addi_minus1",  enc_i(12'hFFF, 3'd0, 7'b0010011), 32'h1, 32'h0, 32'h0, 32'h0);
    run_exp("sltiu_lt",     enc_i(12'hFFF, 3'd3, 7'b0010011), 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h1);
    run_exp("sltiu_eq",     enc_i(12'hFFF, 3'd3, 7'b0010011), 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    run_exp("srai31",       enc_i(12'h41F, 3'd5, 7'b0010011), 32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF);
    run_exp("srli31",       enc_i(12'h01F, 3'd5, 7'b0010011), 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1);
    run_exp("sll_hi_bits",  enc_r(7'h00, 3'd1), 32'hFFFF_FFFF, 32'hFFFF_FFE0, 32'h0, 32'hFFFF_FFFF);
    run_exp("sra_31",       enc_r(7'h20, 3'd5), 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    run_exp("sub",          enc_r(7'h20, 3'd0), 32'h1, 32'h3, 32'h0, 32'hFFFF_FFFE);
    run_exp("add_wrap",     enc_r(7'h00, 3'd0), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF);
    run_exp("branch_zero",  32'h0000_0063, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("branch_flags", {26'b0, eq, neq, lt, ltu, ge, geu}, 32'b010110);
    run_exp("jalr_clear0",  enc_i(12'h003, 3'd0, 7'b1100111), 32'h0000_1000, 32'h0, 32'h0, 32'h0000_1002);
    run_exp("bad_opcode",   32'hFFFF_FF8F, 32'h1234_5678, 32'h0, 32'h4, 32'h0);

`ifdef ALU_OUTPUT_REG_EN
    @(negedge clk);
    instruction = enc_r(7'h00, 3'd0);
    op_a = 32'd5;
    op_b = 32'd7;
    #1;
    check("latency_hold", out, 32'h0);
    @(posedge clk);
    #1;
    check("latency_new", out, 32'd12);
    @(negedge clk);
    op_a  = 32'd100;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset/out", out, 32'h0);
    check("midreset/flags", {26'b0, eq, neq, lt, ltu, ge, geu}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    op_a  = 32'd20;
    @(posedge clk);
    #1;
    check("after_reset", out, 32'd27);
`endif

    for (int i = 0; i < 400; i++) begin
      r   = $urandom();
      opc = opcodes[$urandom_range(0, 9)];
      a   = $urandom();
      b   = $urandom();
      p   = $urandom();
      case ($urandom_range(0, 4))
        0: b = a;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_model($sformatf("rand%0d_op%02h", i, opc), {r[31:7], opc}, a, b, p);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
